// File: rtl/ibex_hart_power_ctrl_if.sv
// ibex_hart_power_ctrl_if: per-hart power-control signal bundle between controller and harts
interface ibex_hart_power_ctrl_if #(parameter int NumHarts = 2);
  logic test_en_i;
  logic alert_clear_i;
  logic [NumHarts-1:0] fetch_enable_i;
  logic [NumHarts-1:0] core_busy_i;
  logic [NumHarts-1:0] irq_pending_i;
  logic [NumHarts-1:0] irq_nm_i;
  logic [NumHarts-1:0] debug_req_i;
  logic [NumHarts-1:0] alert_minor_i;
  logic [NumHarts-1:0] alert_major_i;
  logic [NumHarts-1:0] clock_en_o;
  logic [NumHarts-1:0] core_sleep_o;
  logic [NumHarts-1:0] fetch_enable_o;
  logic [NumHarts-1:0] halted_o;
  logic alert_minor_o;
  logic alert_major_o;
  modport master (
    output test_en_i, alert_clear_i, fetch_enable_i, core_busy_i, irq_pending_i, irq_nm_i,
           debug_req_i, alert_minor_i, alert_major_i,
    input  clock_en_o, core_sleep_o, fetch_enable_o, halted_o, alert_minor_o, alert_major_o
  );
  modport slave (
    input  test_en_i, alert_clear_i, fetch_enable_i, core_busy_i, irq_pending_i, irq_nm_i,
           debug_req_i, alert_minor_i, alert_major_i,
    output clock_en_o, core_sleep_o, fetch_enable_o, halted_o, alert_minor_o, alert_major_o
  );
endinterface

// File: rtl/ibex_hart_power_ctrl.sv
// ibex_hart_power_ctrl: per-hart run/idle/sleep/wake/halt sequencing with clock-gate control
module ibex_hart_power_ctrl #(
  parameter int NumHarts  = 2,
  parameter int IdleHold  = 3,
  parameter int WakeDelay = 2
) (
  input logic clk_i,
  input logic rst_i,
  ibex_hart_power_ctrl_if.slave bus
);
  typedef enum logic [2:0] {OFF, RUN, IDLE_WAIT, SLEEP, WAKE, HALT} state_e;
  localparam logic [7:0] idle_last = 8'(IdleHold - 1);
  localparam logic [7:0] wake_last = 8'(WakeDelay - 1);
  logic alert_minor_q;
  // minor alerts are aggregated and delayed one cycle, never held
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) alert_minor_q <= 1'b0;
    else alert_minor_q <= |bus.alert_minor_i;
  end
  assign bus.alert_minor_o = alert_minor_q;
  assign bus.alert_major_o = |bus.halted_o;
  for (genvar h = 0; h < NumHarts; h++) begin : g_hart
    state_e state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic wake, idle;
    assign wake = bus.irq_pending_i[h] | bus.irq_nm_i[h] | bus.debug_req_i[h];
    assign idle = ~bus.core_busy_i[h] & ~wake;
    // hart state and its dwell counter
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state <= OFF;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end
    // major alert beats run-request loss, which beats normal sequencing; HALT ignores run-request
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (bus.alert_major_i[h]) begin
        state_nxt = HALT;
        cnt_nxt   = '0;
      end else if (!bus.fetch_enable_i[h] && state != HALT) begin
        state_nxt = OFF;
        cnt_nxt   = '0;
      end else begin
        case (state)
          OFF: state_nxt = RUN;
          RUN: if (idle) begin
            state_nxt = (IdleHold == 1) ? SLEEP : IDLE_WAIT;
            cnt_nxt   = (IdleHold == 1) ? 8'd0 : 8'd1;
          end
          IDLE_WAIT: begin
            state_nxt = !idle ? RUN : (cnt >= idle_last) ? SLEEP : IDLE_WAIT;
            cnt_nxt   = (!idle || cnt >= idle_last) ? 8'd0 : cnt + 8'd1;
          end
          SLEEP: if (wake) begin
            state_nxt = WAKE;
            cnt_nxt   = '0;
          end
          WAKE: begin
            state_nxt = (cnt >= wake_last) ? RUN : WAKE;
            cnt_nxt   = (cnt >= wake_last) ? 8'd0 : cnt + 8'd1;
          end
          HALT: if (bus.alert_clear_i) begin
            state_nxt = OFF;
            cnt_nxt   = '0;
          end
          default: begin
            state_nxt = OFF;
            cnt_nxt   = '0;
          end
        endcase
      end
    end
    assign bus.clock_en_o[h]     = (state != SLEEP) || bus.test_en_i;
    assign bus.core_sleep_o[h]   = state == SLEEP;
    assign bus.fetch_enable_o[h] = state inside {RUN, IDLE_WAIT, SLEEP, WAKE};
    assign bus.halted_o[h]       = state == HALT;
  end
endmodule

// File: tb/tb_ibex_hart_power_ctrl.sv
// tb_ibex_hart_power_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_ibex_hart_power_ctrl;
  localparam int N = 2;
  localparam int IH = 3;
  localparam int WD = 2;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  ibex_hart_power_ctrl_if #(.NumHarts(N)) bus ();
  ibex_hart_power_ctrl #(.NumHarts(N), .IdleHold(IH), .WakeDelay(WD)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus)
  );
  always #5 clk_i = ~clk_i;
  int n_chk = 0;
  int n_fail = 0;
  bit m_on[N];
  bit m_sleep[N];
  bit m_halt[N];
  int m_wake_left[N];
  int m_streak[N];
  bit m_minor;

  function automatic void model_reset();
    for (int h = 0; h < N; h++) begin
      m_on[h] = 0; m_sleep[h] = 0; m_halt[h] = 0; m_wake_left[h] = 0; m_streak[h] = 0;
    end
    m_minor = 0;
  endfunction

  function automatic void model_step();
    for (int h = 0; h < N; h++) begin
      bit wk, idl;
      wk  = bus.irq_pending_i[h] | bus.irq_nm_i[h] | bus.debug_req_i[h];
      idl = !bus.core_busy_i[h] && !wk;
      if (bus.alert_major_i[h]) begin
        m_halt[h] = 1; m_on[h] = 0; m_sleep[h] = 0; m_wake_left[h] = 0; m_streak[h] = 0;
      end else if (m_halt[h]) begin
        if (bus.alert_clear_i) m_halt[h] = 0;
      end else if (!bus.fetch_enable_i[h]) begin
        m_on[h] = 0; m_sleep[h] = 0; m_wake_left[h] = 0; m_streak[h] = 0;
      end else if (!m_on[h]) begin
        m_on[h] = 1; m_streak[h] = 0;
      end else if (m_sleep[h]) begin
        if (wk) begin m_sleep[h] = 0; m_wake_left[h] = WD; end
      end else if (m_wake_left[h] > 0) begin
        m_wake_left[h]--;
      end else if (idl) begin
        m_streak[h]++;
        if (m_streak[h] == IH) begin m_sleep[h] = 1; m_streak[h] = 0; end
      end else begin
        m_streak[h] = 0;
      end
    end
    m_minor = |bus.alert_minor_i;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic drive_quiet();
    bus.test_en_i = 0; bus.alert_clear_i = 0; bus.fetch_enable_i = '0; bus.core_busy_i = '0;
    bus.irq_pending_i = '0; bus.irq_nm_i = '0; bus.debug_req_i = '0;
    bus.alert_minor_i = '0; bus.alert_major_i = '0;
  endtask

  task automatic test_reset();
    drive_quiet();
    rst_i = 1;
    bus.fetch_enable_i = '1; bus.alert_minor_i = '1; bus.alert_major_i = '1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_chk += 6;
    if (bus.clock_en_o !== 2'b11) begin n_fail++; $display("FAIL reset_clock_en got %b exp 11", bus.clock_en_o); end
    if (bus.core_sleep_o !== 2'b00) begin n_fail++; $display("FAIL reset_core_sleep got %b exp 00", bus.core_sleep_o); end
    if (bus.fetch_enable_o !== 2'b00) begin n_fail++; $display("FAIL reset_fetch_en got %b exp 00", bus.fetch_enable_o); end
    if (bus.halted_o !== 2'b00) begin n_fail++; $display("FAIL reset_halted got %b exp 00", bus.halted_o); end
    if (bus.alert_minor_o !== 1'b0) begin n_fail++; $display("FAIL reset_alert_minor got %b exp 0", bus.alert_minor_o); end
    if (bus.alert_major_o !== 1'b0) begin n_fail++; $display("FAIL reset_alert_major got %b exp 0", bus.alert_major_o); end
    drive_quiet();
    rst_i = 0;
    model_reset();
  endtask

  task automatic test_sleep_entry();
    bus.fetch_enable_i = 2'b01;
    tick();
    n_chk++;
    if (bus.fetch_enable_o !== 2'b01) begin n_fail++; $display("FAIL run_cycle1 fetch_en got %b exp 01", bus.fetch_enable_o); end
    tick(); tick();
    n_chk++;
    if (bus.core_sleep_o !== 2'b00) begin n_fail++; $display("FAIL idle_cycle3 core_sleep got %b exp 00", bus.core_sleep_o); end
    tick();
    n_chk += 2;
    if (bus.core_sleep_o !== 2'b01) begin n_fail++; $display("FAIL sleep_cycle4 core_sleep got %b exp 01", bus.core_sleep_o); end
    if (bus.clock_en_o !== 2'b10) begin n_fail++; $display("FAIL sleep_cycle4 clock_en got %b exp 10", bus.clock_en_o); end
  endtask

  task automatic test_wake();
    bus.irq_pending_i = 2'b01;
    tick();
    bus.irq_pending_i = 2'b00;
    n_chk += 2;
    if (bus.clock_en_o[0] !== 1'b1) begin n_fail++; $display("FAIL wake_clock_en got %b exp 1", bus.clock_en_o[0]); end
    if (bus.core_sleep_o[0] !== 1'b0) begin n_fail++; $display("FAIL wake_core_sleep got %b exp 0", bus.core_sleep_o[0]); end
    repeat (4) tick();
    n_chk++;
    if (bus.core_sleep_o[0] !== 1'b0) begin n_fail++; $display("FAIL wake_resleep_early got %b exp 0", bus.core_sleep_o[0]); end
    tick();
    n_chk++;
    if (bus.core_sleep_o[0] !== 1'b1) begin n_fail++; $display("FAIL wake_resleep got %b exp 1", bus.core_sleep_o[0]); end
  endtask

  task automatic test_idle_interrupt();
    bus.irq_nm_i = 2'b01;
    tick();
    bus.irq_nm_i = 2'b00;
    repeat (4) tick();
    bus.core_busy_i = 2'b01;
    tick();
    bus.core_busy_i = 2'b00;
    tick(); tick();
    n_chk++;
    if (bus.core_sleep_o[0] !== 1'b0) begin n_fail++; $display("FAIL busy_restart_early got %b exp 0", bus.core_sleep_o[0]); end
    tick();
    n_chk++;
    if (bus.core_sleep_o[0] !== 1'b1) begin n_fail++; $display("FAIL busy_restart_sleep got %b exp 1", bus.core_sleep_o[0]); end
  endtask

  task automatic test_halt();
    bus.fetch_enable_i = 2'b11;
    repeat (4) tick();
    n_chk++;
    if (bus.core_sleep_o !== 2'b11) begin n_fail++; $display("FAIL both_sleep got %b exp 11", bus.core_sleep_o); end
    bus.alert_major_i = 2'b10; bus.debug_req_i = 2'b10;
    tick();
    bus.alert_major_i = 2'b00; bus.debug_req_i = 2'b00;
    n_chk += 4;
    if (bus.halted_o !== 2'b10) begin n_fail++; $display("FAIL halt_halted got %b exp 10", bus.halted_o); end
    if (bus.alert_major_o !== 1'b1) begin n_fail++; $display("FAIL halt_alert_major got %b exp 1", bus.alert_major_o); end
    if (bus.fetch_enable_o !== 2'b01) begin n_fail++; $display("FAIL halt_fetch_en got %b exp 01", bus.fetch_enable_o); end
    if (bus.core_sleep_o !== 2'b01) begin n_fail++; $display("FAIL halt_core_sleep got %b exp 01", bus.core_sleep_o); end
    tick();
    n_chk++;
    if (bus.halted_o !== 2'b10) begin n_fail++; $display("FAIL halt_sticky got %b exp 10", bus.halted_o); end
    bus.alert_clear_i = 1;
    tick();
    bus.alert_clear_i = 0;
    n_chk += 3;
    if (bus.halted_o !== 2'b00) begin n_fail++; $display("FAIL clear_halted got %b exp 00", bus.halted_o); end
    if (bus.alert_major_o !== 1'b0) begin n_fail++; $display("FAIL clear_alert_major got %b exp 0", bus.alert_major_o); end
    if (bus.fetch_enable_o !== 2'b01) begin n_fail++; $display("FAIL clear_to_off got %b exp 01", bus.fetch_enable_o); end
    bus.alert_major_i = 2'b10;
    tick();
    bus.alert_clear_i = 1;
    tick();
    bus.alert_major_i = 2'b00; bus.alert_clear_i = 0;
    n_chk++;
    if (bus.halted_o !== 2'b10) begin n_fail++; $display("FAIL clear_with_major got %b exp 10", bus.halted_o); end
    bus.alert_minor_i = 2'b01;
    tick();
    bus.alert_minor_i = 2'b00;
    n_chk++;
    if (bus.alert_minor_o !== 1'b1) begin n_fail++; $display("FAIL minor_set got %b exp 1", bus.alert_minor_o); end
    bus.alert_clear_i = 1;
    tick();
    bus.alert_clear_i = 0;
    n_chk += 2;
    if (bus.alert_minor_o !== 1'b0) begin n_fail++; $display("FAIL minor_not_sticky got %b exp 0", bus.alert_minor_o); end
    if (bus.halted_o !== 2'b00) begin n_fail++; $display("FAIL second_clear got %b exp 00", bus.halted_o); end
    bus.fetch_enable_i = 2'b01;
  endtask

  task automatic test_test_en();
    tick();
    n_chk++;
    if (bus.core_sleep_o !== 2'b01) begin n_fail++; $display("FAIL testen_pre_sleep got %b exp 01", bus.core_sleep_o); end
    bus.test_en_i = 1;
    #1;
    n_chk += 2;
    if (bus.clock_en_o[0] !== 1'b1) begin n_fail++; $display("FAIL testen_clock_en got %b exp 1", bus.clock_en_o[0]); end
    if (bus.core_sleep_o[0] !== 1'b1) begin n_fail++; $display("FAIL testen_core_sleep got %b exp 1", bus.core_sleep_o[0]); end
    bus.test_en_i = 0;
    #1;
    n_chk++;
    if (bus.clock_en_o[0] !== 1'b0) begin n_fail++; $display("FAIL testen_release got %b exp 0", bus.clock_en_o[0]); end
    @(negedge clk_i);
    bus.fetch_enable_i = 2'b00;
    tick();
    n_chk += 3;
    if (bus.fetch_enable_o[0] !== 1'b0) begin n_fail++; $display("FAIL drop_fetch_en got %b exp 0", bus.fetch_enable_o[0]); end
    if (bus.core_sleep_o[0] !== 1'b0) begin n_fail++; $display("FAIL drop_core_sleep got %b exp 0", bus.core_sleep_o[0]); end
    if (bus.clock_en_o[0] !== 1'b1) begin n_fail++; $display("FAIL drop_clock_en got %b exp 1", bus.clock_en_o[0]); end
  endtask

  task automatic test_async_reset();
    bus.fetch_enable_i = 2'b01;
    repeat (4) tick();
    n_chk++;
    if (bus.clock_en_o[0] !== 1'b0) begin n_fail++; $display("FAIL areset_pre_sleep got %b exp 0", bus.clock_en_o[0]); end
    #2 rst_i = 1;
    #1;
    n_chk += 4;
    if (bus.clock_en_o !== 2'b11) begin n_fail++; $display("FAIL areset_clock_en got %b exp 11", bus.clock_en_o); end
    if (bus.core_sleep_o !== 2'b00) begin n_fail++; $display("FAIL areset_core_sleep got %b exp 00", bus.core_sleep_o); end
    if (bus.fetch_enable_o !== 2'b00) begin n_fail++; $display("FAIL areset_fetch_en got %b exp 00", bus.fetch_enable_o); end
    if ({bus.halted_o, bus.alert_major_o, bus.alert_minor_o} !== 4'b0) begin n_fail++; $display("FAIL areset_alerts got %b exp 0000", {bus.halted_o, bus.alert_major_o, bus.alert_minor_o}); end
    @(negedge clk_i);
    rst_i = 0;
    model_reset();
    tick();
    n_chk++;
    if (bus.fetch_enable_o !== 2'b01) begin n_fail++; $display("FAIL post_reset_first_edge got %b exp 01", bus.fetch_enable_o); end
  endtask

  task automatic test_random();
    logic [N-1:0] e_ce, e_sl, e_fe, e_ht;
    for (int i = 0; i < 600; i++) begin
      for (int h = 0; h < N; h++) begin
        bus.fetch_enable_i[h] = $urandom_range(15) != 0;
        bus.core_busy_i[h]    = $urandom_range(1) != 0;
        bus.irq_pending_i[h]  = $urandom_range(11) == 0;
        bus.irq_nm_i[h]       = $urandom_range(23) == 0;
        bus.debug_req_i[h]    = $urandom_range(23) == 0;
        bus.alert_minor_i[h]  = $urandom_range(5) == 0;
        bus.alert_major_i[h]  = $urandom_range(39) == 0;
      end
      bus.alert_clear_i = $urandom_range(7) == 0;
      bus.test_en_i     = $urandom_range(9) == 0;
      tick();
      for (int h = 0; h < N; h++) begin
        e_sl[h] = m_sleep[h];
        e_fe[h] = m_on[h];
        e_ht[h] = m_halt[h];
        e_ce[h] = !m_sleep[h] || bus.test_en_i;
      end
      n_chk += 6;
      if (bus.clock_en_o !== e_ce) begin n_fail++; $display("FAIL rnd%0d clock_en got %b exp %b", i, bus.clock_en_o, e_ce); end
      if (bus.core_sleep_o !== e_sl) begin n_fail++; $display("FAIL rnd%0d core_sleep got %b exp %b", i, bus.core_sleep_o, e_sl); end
      if (bus.fetch_enable_o !== e_fe) begin n_fail++; $display("FAIL rnd%0d fetch_en got %b exp %b", i, bus.fetch_enable_o, e_fe); end
      if (bus.halted_o !== e_ht) begin n_fail++; $display("FAIL rnd%0d halted got %b exp %b", i, bus.halted_o, e_ht); end
      if (bus.alert_major_o !== |e_ht) begin n_fail++; $display("FAIL rnd%0d alert_major got %b exp %b", i, bus.alert_major_o, |e_ht); end
      if (bus.alert_minor_o !== m_minor) begin n_fail++; $display("FAIL rnd%0d alert_minor got %b exp %b", i, bus.alert_minor_o, m_minor); end
    end
  endtask

  initial begin
    test_reset();
    test_sleep_entry();
    test_wake();
    test_idle_interrupt();
    test_halt();
    test_test_en();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
